seq_detect_param: RTL
=====================

Name: seq_detect_param

Overview:
Parametrised, runtime-programmable serial pattern detector. It is the successor to the fixed 4-bit "1011" detector.
- Pattern value and length (1..PAT_W) are programmable.
- Input is qualified by a valid strobe.
- Overlapping or non-overlapping matching is selectable at runtime.
- Sits on serial bit streams: framing/sync-word search ahead of deserialisers.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(PAT_W+1), width of pat_len.
- CNT_W, 16, width of the match counter (optional feature only).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- inp_bit  in  1  serial data bit.
- inp_valid  in  1  inp_bit is sampled only when inp_valid=1.
- enable  in  1  detection enable; 0 holds the block in IDLE.
- overlap_en  in  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_load  in  1  single-cycle strobe; captures cfg_pat and cfg_len.
- cfg_pat  in  PAT_W  pattern. The first bit received is cfg_pat[len-1]; the last bit received is cfg_pat[0].
- cfg_len  in  LEN_W  pattern length.
- seq_seen  out  1  registered, one-cycle match pulse.
- cfg_err  out  1  sticky flag: an illegal cfg_len was loaded.
- match_cnt  out  CNT_W  match count (only when SEQ_DETECT_MATCH_CNT_EN is defined).

Behaviour:
- Reset (reset_n=0, asynchronous) sets:
  - pat_r = 'b1011 (zero-extended), len_r = 4
  - hist = 0, fill = 0, state = IDLE
  - seq_seen = 0, cfg_err = 0, match_cnt = 0
- Reset release is synchronous to clk.
- Registers:
  - hist[PAT_W-1:0]: shift history. On each accepted bit, hist <= {hist[PAT_W-2:0], inp_bit}.
  - fill: count of valid history bits, saturating at len_r.
- An accepted bit is a cycle with inp_valid=1, enable=1 and cfg_load=0.
- FSM states:
  - IDLE: entered when enable=0; hist and fill are cleared. Goes to FILL when enable=1.
  - FILL: fill < len_r. Each accepted bit shifts hist and increments fill. When fill reaches len_r-1 and the bit is accepted, the match check runs on the same edge and the FSM goes to HUNT.
  - HUNT: each accepted bit shifts hist and runs the match check.
- Match check: compare the len_r LSBs of the new history against the len_r LSBs of pat_r. Bits above len_r are ignored.
- On a match:
  - seq_seen = 1 in the cycle after the accepting edge. Latency is 1 clk from the final bit's sampling edge.
  - seq_seen is 0 in every other cycle, including cycles with inp_valid=0.
- After a match:
  - overlap_en=1: stay in HUNT; history is retained. Example: 1011011 gives 2 matches.
  - overlap_en=0: fill <= 0, FSM goes to FILL, and len_r fresh bits are needed. Example: 1011011 gives 1 match.
- cfg_load=1 (takes priority over data):
  - pat_r <= cfg_pat.
  - len_r <= cfg_len. If cfg_len is 0 or greater than PAT_W, len_r <= PAT_W and cfg_err is set.
  - hist and fill are cleared; the FSM goes to FILL, or IDLE if enable=0.
  - inp_bit in that cycle is discarded.
  - seq_seen is 0 in the next cycle.
- cfg_err is cleared only by reset.
- overlap_en is sampled each cycle. A change takes effect at the next match.
- enable deasserted mid-stream: the partial history is discarded and no pulse is generated.
- len_r = 1: every accepted bit equal to pat_r[0] pulses seq_seen. With overlap_en=0 it behaves identically.

Optional Feature:
SEQ_DETECT_MATCH_CNT_EN
- Defined:
  - match_cnt (CNT_W bits) increments on every match and saturates at all-ones. It does not wrap.
  - Cleared by reset and by cfg_load.
- Not defined:
  - The match_cnt port and its counter are absent.
  - All other behaviour is identical.

Decomposition:
- Package seq_detect_pkg holds:
  - the state encoding: IDLE=0, FILL=1, HUNT=2, 2-bit
  - the reset pattern constant DEF_PAT='b1011 and DEF_LEN=4
- Sub-module seq_match_cmp: combinational masked comparator.
  - Inputs: hist_next, pat_r, len_r.
  - Output: hit.
  - Parametrised by PAT_W.
- FSM, fill counter, config registers and the optional counter stay in the top module.

Test Plan:
1. Reset defaults, enable=1, overlap_en=1, drive valid bits 1,0,1,1 → seq_seen=1 exactly one cycle after the 4th bit; cfg_err=0.
2. overlap_en=1, stream 1,0,1,1,0,1,1 → 2 pulses, after bits 4 and 7. Repeat with overlap_en=0 → 1 pulse only.
3. Stream 1,0,1,1 with inp_valid=0 inserted after each bit (idle cycles) → single pulse, one cycle after the last valid bit; seq_seen=0 during all gaps.
4. cfg_load with cfg_pat=8'hA5, cfg_len=8, then send 10100101 → one pulse. cfg_load mid-match (after 3 bits) → partial history is discarded, and the full 8-bit sequence is needed afterwards.
5. cfg_len=0 → cfg_err=1 and len_r=PAT_W. Assert reset_n=0 asynchronously between clock edges mid-stream → all outputs 0 immediately, and the pattern reverts to 1011/4.
6. With SEQ_DETECT_MATCH_CNT_EN defined, CNT_W=2, len=1, pat=1, send 5 ones → match_cnt 1,2,3,3,3 (saturates); cfg_load clears it to 0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// FSM state encoding and the power-on pattern (1011, length 4).
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  localparam int DEF_PAT = 'b1011;
  localparam int DEF_LEN = 4;

endpackage

// File: rtl/seq_match_cmp.sv
// Masked comparator: hit when the len_r LSBs of hist_next equal the len_r
// LSBs of pat_r; bits at or above len_r are ignored.
module seq_match_cmp #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-1:0] hist_next,
  input  logic [PAT_W-1:0] pat_r,
  input  logic [LEN_W-1:0] len_r,
  output logic             hit
);

  logic [PAT_W-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_r);
    end
  end

  assign hit = (((hist_next ^ pat_r) & mask) == '0);

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control.
// Optional saturating match counter enabled by SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inp_bit,
  input  logic             inp_valid,
  input  logic             enable,
  input  logic             overlap_en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             seq_seen,
`ifdef SEQ_DETECT_MATCH_CNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             cfg_err
);

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic [PAT_W-1:0] hist, hist_n, hist_next;
  logic [LEN_W-1:0] fill, fill_n, fill_inc;
  logic             hit;
  logic             match;
  logic             len_ok;
  // Oldest history bit never reaches the comparator (it only sees hist_next).
  logic             hist_msb_unused;

  assign hist_next       = {hist[PAT_W-2:0], inp_bit};
  assign hist_msb_unused = hist[PAT_W-1];
  assign fill_inc        = fill + LEN_W'(1);
  assign len_ok          = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

  seq_match_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .hist_next (hist_next),
    .pat_r     (pat_r),
    .len_r     (len_r),
    .hit       (hit)
  );

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    match   = 1'b0;
    if (cfg_load) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = enable ? FILL : IDLE;
    end else if (!enable) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = IDLE;
    end else begin
      case (state)
        HUNT: begin
          if (inp_valid) begin
            hist_n = hist_next;
            if (hit) begin
              match = 1'b1;
              if (!overlap_en) begin
                fill_n  = '0;
                state_n = FILL;
              end
            end
          end
        end
        default: begin
          // IDLE with enable high behaves as FILL with an empty history.
          state_n = FILL;
          if (inp_valid) begin
            hist_n = hist_next;
            if (fill_inc >= len_r) begin
              match = hit;
              if (hit && !overlap_en) begin
                fill_n = '0;
              end else begin
                fill_n  = len_r;
                state_n = HUNT;
              end
            end else begin
              fill_n = fill_inc;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hist     <= '0;
      fill     <= '0;
      pat_r    <= PAT_W'(DEF_PAT);
      len_r    <= LEN_W'(DEF_LEN);
      seq_seen <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      hist     <= hist_n;
      fill     <= fill_n;
      seq_seen <= match;
      if (cfg_load) begin
        pat_r <= cfg_pat;
        len_r <= len_ok ? cfg_len : LEN_W'(PAT_W);
        if (!len_ok) cfg_err <= 1'b1;
      end
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= '0;
    end else if (cfg_load) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  localparam int CNT_W_UNUSED = CNT_W;
`endif

endmodule
